// File: rtl/tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tx_frame_ctrl
//   Transmit sequencer in front of an 8b/10b encoder. After reset it sends a
//   link bring-up run of K28.5 commas. Once the link is up it frames payload
//   bytes from a valid/ready source as K27.7 (SOF), data bytes, K29.7 (EOF).
//   Gaps between frames are filled with K28.5. A frame that underruns or
//   overruns MAX_LEN is terminated with K30.7, and the rest of that frame is
//   discarded. Exactly one symbol is presented to the encoder per clock.
//
// Ports
//   clk       in   clock, all state updates on posedge
//   reset     in   asynchronous, active-high reset
//   in_valid  in   upstream byte valid, held with data until accepted
//   in_data   in   upstream payload byte
//   in_last   in   final byte of a frame, qualified by in_valid
//   in_ready  out  byte accepted on a posedge where in_valid & in_ready
//   enc_data  out  symbol for the encoder data input (registered)
//   enc_k     out  control-symbol flag for the encoder (registered)
//   enc_enb   out  encoder enable (registered)
//   link_up   out  high once the sync run has completed, sticky (registered)
// -----------------------------------------------------------------------------
module tx_frame_ctrl #(
  parameter int SYNC_LEN = 4,
  parameter int IDLE_MIN = 2,
  parameter int MAX_LEN  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       enc_enb,
  output logic       link_up
);

  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int IW = $clog2(IDLE_MIN + 1);
  localparam int BW = $clog2(MAX_LEN + 1);

  localparam logic [SW-1:0] SYNC_LEN_C = SW'(SYNC_LEN);
  localparam logic [IW-1:0] IDLE_MIN_C = IW'(IDLE_MIN);
  localparam logic [BW-1:0] MAX_LEN_C  = BW'(MAX_LEN);

  localparam logic [7:0] K_IDLE  = 8'hBC;  // K28.5
  localparam logic [7:0] K_SOF   = 8'hFB;  // K27.7
  localparam logic [7:0] K_EOF   = 8'hFD;  // K29.7
  localparam logic [7:0] K_ABORT = 8'hFE;  // K30.7

  // The state always names the symbol currently driven on enc_data/enc_k.
  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SOF   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_EOF   = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;
  localparam logic [2:0] ST_DROP  = 3'd6;

  logic [2:0]    state_reg,    state_next;
  logic [SW-1:0] sync_cnt_reg, sync_cnt_next;
  logic [IW-1:0] idle_cnt_reg, idle_cnt_next;
  logic [BW-1:0] byte_cnt_reg, byte_cnt_next;
  // Set while the byte on enc_data carried in_last: the following symbol must
  // be EOF, so no further byte may be taken in that cycle.
  logic          last_reg,     last_next;
  logic [7:0]    enc_data_reg, enc_data_next;
  logic          enc_k_reg,    enc_k_next;
  logic          enc_enb_reg,  enc_enb_next;
  logic          link_up_reg,  link_up_next;

  logic          accept;
  logic [IW-1:0] idle_inc;

  assign enc_data = enc_data_reg;
  assign enc_k    = enc_k_reg;
  assign enc_enb  = enc_enb_reg;
  assign link_up  = link_up_reg;

  // Ready is a function of registered state only, never of in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      ST_SOF:  in_ready = 1'b1;
      ST_DATA: in_ready = (byte_cnt_reg < MAX_LEN_C) && !last_reg;
      ST_DROP: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // idle_cnt counts gap symbols including the one on the line now, so the
  // gap between EOF/abort and SOF is exactly IDLE_MIN symbols when a frame
  // is already waiting.
  assign idle_inc = (idle_cnt_reg == IDLE_MIN_C) ? idle_cnt_reg
                                                 : idle_cnt_reg + IW'(1);

  always_comb begin
    state_next    = state_reg;
    sync_cnt_next = sync_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    last_next     = last_reg;
    link_up_next  = link_up_reg;
    enc_enb_next  = 1'b1;
    enc_data_next = K_IDLE;
    enc_k_next    = 1'b1;

    case (state_reg)
      ST_SYNC: begin
        if (sync_cnt_reg == SYNC_LEN_C) begin
          link_up_next  = 1'b1;
          state_next    = ST_IDLE;
          idle_cnt_next = '0;
        end else begin
          sync_cnt_next = sync_cnt_reg + SW'(1);
        end
      end

      ST_IDLE: begin
        idle_cnt_next = idle_inc;
        if (idle_inc >= IDLE_MIN_C && in_valid) begin
          state_next    = ST_SOF;
          enc_data_next = K_SOF;
          byte_cnt_next = '0;
          last_next     = 1'b0;
        end
      end

      ST_SOF, ST_DATA: begin
        if (accept) begin
          enc_data_next = in_data;
          enc_k_next    = 1'b0;
          byte_cnt_next = byte_cnt_reg + BW'(1);
          last_next     = in_last;
          state_next    = ST_DATA;
        end else if (state_reg == ST_DATA && last_reg) begin
          enc_data_next = K_EOF;
          state_next    = ST_EOF;
        end else begin
          // Underrun in SOF/DATA, or MAX_LEN reached without a last byte.
          enc_data_next = K_ABORT;
          state_next    = ST_ABORT;
        end
      end

      ST_EOF: begin
        state_next    = ST_IDLE;
        idle_cnt_next = '0;
      end

      ST_ABORT: begin
        // Nothing left to discard if the frame's last byte was already taken.
        if (last_reg) begin
          state_next    = ST_IDLE;
          idle_cnt_next = '0;
        end else begin
          state_next    = ST_DROP;
        end
      end

      ST_DROP: begin
        if (accept && in_last) begin
          state_next    = ST_IDLE;
          idle_cnt_next = '0;
        end
      end

      default: begin
        state_next = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_SYNC;
      sync_cnt_reg <= '0;
      idle_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      last_reg     <= 1'b0;
      enc_data_reg <= K_IDLE;
      enc_k_reg    <= 1'b1;
      enc_enb_reg  <= 1'b0;
      link_up_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sync_cnt_reg <= sync_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      last_reg     <= last_next;
      enc_data_reg <= enc_data_next;
      enc_k_reg    <= enc_k_next;
      enc_enb_reg  <= enc_enb_next;
      link_up_reg  <= link_up_next;
    end
  end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_ctrl
//   Table-driven bench for tx_frame_ctrl (SYNC_LEN=4, IDLE_MIN=2, MAX_LEN=16).
//   Each table row holds the inputs driven for one cycle and the outputs
//   expected during that cycle. Rows are applied on the falling edge and
//   outputs are sampled 1 time unit later. A hand-written sequence covers
//   reset in the middle of a frame and the replayed sync run.
// -----------------------------------------------------------------------------
module tb_tx_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] enc_data;
  logic       enc_k;
  logic       enc_enb;
  logic       link_up;

  int checks   = 0;
  int failures = 0;

  tx_frame_ctrl #(
    .SYNC_LEN(4),
    .IDLE_MIN(2),
    .MAX_LEN (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_last (in_last),
    .in_ready(in_ready),
    .enc_data(enc_data),
    .enc_k   (enc_k),
    .enc_enb (enc_enb),
    .link_up (link_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       rdy;
    logic [7:0] ed;
    logic       ek;
    logic       eb;
    logic       lu;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic v, input logic [7:0] d,
                     input logic l, input logic rdy, input logic [7:0] ed,
                     input logic ek, input logic eb, input logic lu);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.l = l;
    t.rdy = rdy; t.ed = ed; t.ek = ek; t.eb = eb; t.lu = lu;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic found;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;

    // ---- reset and sync run ----
    add(1, 0, 8'h00, 0,  0, 8'hBC, 1, 0, 0);
    add(0, 0, 8'h00, 0,  0, 8'hBC, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 8'h00, 0,  0, 8'hBC, 1, 1, 0);
    // ---- frame 11,22,33 then back-to-back single-byte frame 44 ----
    add(0, 1, 8'h11, 0,  0, 8'hBC, 1, 1, 1);
    add(0, 1, 8'h11, 0,  0, 8'hBC, 1, 1, 1);
    add(0, 1, 8'h11, 0,  1, 8'hFB, 1, 1, 1);
    add(0, 1, 8'h22, 0,  1, 8'h11, 0, 1, 1);
    add(0, 1, 8'h33, 1,  1, 8'h22, 0, 1, 1);
    add(0, 1, 8'h44, 1,  0, 8'h33, 0, 1, 1);
    add(0, 1, 8'h44, 1,  0, 8'hFD, 1, 1, 1);
    add(0, 1, 8'h44, 1,  0, 8'hBC, 1, 1, 1);
    add(0, 1, 8'h44, 1,  0, 8'hBC, 1, 1, 1);
    add(0, 1, 8'h44, 1,  1, 8'hFB, 1, 1, 1);
    add(0, 0, 8'h00, 0,  0, 8'h44, 0, 1, 1);
    add(0, 0, 8'h00, 0,  0, 8'hFD, 1, 1, 1);
    // ---- underrun after 2nd byte (2nd byte equals K28.5, sent as data) ----
    add(0, 1, 8'hA1, 0,  0, 8'hBC, 1, 1, 1);
    add(0, 1, 8'hA1, 0,  0, 8'hBC, 1, 1, 1);
    add(0, 1, 8'hA1, 0,  1, 8'hFB, 1, 1, 1);
    add(0, 1, 8'hBC, 0,  1, 8'hA1, 0, 1, 1);
    add(0, 0, 8'h00, 0,  1, 8'hBC, 0, 1, 1);
    add(0, 1, 8'hA3, 0,  0, 8'hFE, 1, 1, 1);
    add(0, 1, 8'hA3, 0,  1, 8'hBC, 1, 1, 1);
    add(0, 1, 8'hA4, 0,  1, 8'hBC, 1, 1, 1);
    add(0, 1, 8'hA5, 1,  1, 8'hBC, 1, 1, 1);
    add(0, 0, 8'h00, 0,  0, 8'hBC, 1, 1, 1);
    add(0, 0, 8'h00, 0,  0, 8'hBC, 1, 1, 1);
    // ---- 20-byte frame: 16 forwarded, abort, 4 dropped ----
    add(0, 1, 8'h01, 0,  0, 8'hBC, 1, 1, 1);
    add(0, 1, 8'h01, 0,  1, 8'hFB, 1, 1, 1);
    for (int k = 1; k <= 16; k++)
      add(0, 1, (k < 16) ? 8'(k + 1) : 8'd17, 0,  (k < 16), 8'(k), 0, 1, 1);
    add(0, 1, 8'd17, 0,  0, 8'hFE, 1, 1, 1);
    for (int k = 17; k <= 20; k++)
      add(0, 1, 8'(k), (k == 20),  1, 8'hBC, 1, 1, 1);
    add(0, 0, 8'h00, 0,  0, 8'hBC, 1, 1, 1);
    add(0, 0, 8'h00, 0,  0, 8'hBC, 1, 1, 1);
    // ---- next frame framed normally ----
    add(0, 1, 8'h55, 0,  0, 8'hBC, 1, 1, 1);
    add(0, 1, 8'h55, 0,  1, 8'hFB, 1, 1, 1);
    add(0, 1, 8'h66, 1,  1, 8'h55, 0, 1, 1);
    add(0, 0, 8'h00, 0,  0, 8'h66, 0, 1, 1);
    add(0, 0, 8'h00, 0,  0, 8'hFD, 1, 1, 1);
    add(0, 0, 8'h00, 0,  0, 8'hBC, 1, 1, 1);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset    = vecs[i].rst;
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      in_last  = vecs[i].l;
      #1;
      $display("vec %0d: rst=%b v=%b d=%h l=%b | rdy=%b data=%h k=%b enb=%b link=%b",
               i, reset, in_valid, in_data, in_last, in_ready, enc_data, enc_k, enc_enb, link_up);
      chk($sformatf("vec%0d_in_ready", i), {7'd0, in_ready}, {7'd0, vecs[i].rdy});
      chk($sformatf("vec%0d_enc_data", i), enc_data, vecs[i].ed);
      chk($sformatf("vec%0d_enc_k", i),    {7'd0, enc_k},    {7'd0, vecs[i].ek});
      chk($sformatf("vec%0d_enc_enb", i),  {7'd0, enc_enb},  {7'd0, vecs[i].eb});
      chk($sformatf("vec%0d_link_up", i),  {7'd0, link_up},  {7'd0, vecs[i].lu});
    end

    // ---- reset asserted while a data byte is on the line ----
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_last  = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1;
      if (enc_k === 1'b0 && enc_data === 8'h77) found = 1'b1;
    end
    chk("mid_frame_data_seen", {7'd0, found}, 8'd1);
    $display("seq reset: data byte on line found=%b", found);

    @(negedge clk);
    reset = 1'b1;
    #1;
    $display("seq reset: asserted rdy=%b data=%h k=%b enb=%b link=%b",
             in_ready, enc_data, enc_k, enc_enb, link_up);
    chk("rst_mid_enc_data", enc_data, 8'hBC);
    chk("rst_mid_enc_k",    {7'd0, enc_k},    8'd1);
    chk("rst_mid_enc_enb",  {7'd0, enc_enb},  8'd0);
    chk("rst_mid_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_mid_link_up",  {7'd0, link_up},  8'd0);

    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel_enc_enb", {7'd0, enc_enb}, 8'd0);

    n = 0;
    for (int i = 0; i < 20 && link_up !== 1'b1; i++) begin
      @(posedge clk);
      n++;
      #1;
      chk($sformatf("resync%0d_enc_enb", n),  {7'd0, enc_enb},  8'd1);
      chk($sformatf("resync%0d_enc_data", n), enc_data, 8'hBC);
      chk($sformatf("resync%0d_in_ready", n), {7'd0, in_ready}, 8'd0);
    end
    $display("seq reset: link_up after %0d edges", n);
    chk("resync_edges_to_link_up", 8'(n), 8'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
